// File: rtl/pzx_sram_arbiter.sv
// -----------------------------------------------------------------------------
// pzx_sram_arbiter
//
// Shares one external 8-bit asynchronous SRAM between the host (loader/CPU,
// read/write) and the PZX player (read only). Each access runs through a fixed
// sequence IDLE -> SETUP -> STROBE (STROBE_CYCLES) -> HOLD -> IDLE, so an
// access always takes STROBE_CYCLES+3 cycles from the request being seen in
// IDLE to IDLE being re-entered. Ties are resolved round robin.
//
// Parameters
//   STROBE_CYCLES : length of the STROBE phase in cycles (1..15)
//
// Ports
//   clk, rst             : single clock domain, synchronous active-high reset
//   host_req/we/addr/wdata : host request, held until host_ack
//   host_rdata, host_ack : host read data (held between reads), 1-cycle ack
//   play_req/addr        : player read request, held until play_ack
//   play_rdata, play_ack : player read data (held between reads), 1-cycle ack
//   sram_addr            : SRAM address, registered at grant, held in IDLE
//   sram_dout, sram_oe   : write data and its drive enable (tristate built above)
//   sram_din             : data returned by the SRAM
//   sram_we_n            : active-low write strobe, low only in STROBE of a write
//   busy                 : high whenever an access is in progress
// -----------------------------------------------------------------------------
module pzx_sram_arbiter #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [20:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_ack,
    input  logic        play_req,
    input  logic [20:0] play_addr,
    output logic [7:0]  play_rdata,
    output logic        play_ack,
    output logic [20:0] sram_addr,
    output logic [7:0]  sram_dout,
    output logic        sram_oe,
    input  logic [7:0]  sram_din,
    output logic        sram_we_n,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  strobe_cnt;
    logic        grant_play;    // current access belongs to the player
    logic        access_write;  // current access is a host write
    logic        last_play;     // last grant went to the player
    logic        any_req;
    logic        take_play;
    logic        strobe_done;

    assign any_req = host_req | play_req;

    // Player wins when alone, or on a tie when the host was served last.
    assign take_play = play_req & (~host_req | ~last_play);

    assign strobe_done = (state == STROBE) && (strobe_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        sram_oe    = 1'b0;
        sram_we_n  = 1'b1;
        host_ack   = 1'b0;
        play_ack   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_req) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                sram_oe    = access_write;
                state_next = STROBE;
            end
            STROBE: begin
                sram_oe   = access_write;
                sram_we_n = ~access_write;
                if (strobe_cnt == 4'd0) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                sram_oe    = access_write;
                host_ack   = ~grant_play;
                play_ack   = grant_play;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_play   <= 1'b0;
            access_write <= 1'b0;
            last_play    <= 1'b0;
            strobe_cnt   <= 4'd0;
            sram_addr    <= 21'd0;
            sram_dout    <= 8'd0;
            host_rdata   <= 8'd0;
            play_rdata   <= 8'd0;
        end else begin
            // Everything the access needs is captured at grant, so requester
            // inputs may change freely afterwards.
            if (state == IDLE && any_req) begin
                grant_play   <= take_play;
                last_play    <= take_play;
                access_write <= ~take_play & host_we;
                sram_addr    <= take_play ? play_addr : host_addr;
                if (~take_play & host_we) begin
                    sram_dout <= host_wdata;
                end
            end

            if (state == SETUP) begin
                strobe_cnt <= STROBE_LOAD;
            end else if (state == STROBE && strobe_cnt != 4'd0) begin
                strobe_cnt <= strobe_cnt - 4'd1;
            end

            // Read data is taken at the end of the last STROBE cycle, when the
            // SRAM output has had the full strobe time to settle.
            if (strobe_done && !access_write) begin
                if (grant_play) begin
                    play_rdata <= sram_din;
                end else begin
                    host_rdata <= sram_din;
                end
            end
        end
    end

endmodule

// File: tb/tb_pzx_sram_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for pzx_sram_arbiter.
// A transaction-level reference model predicts each access (winner, address,
// data, ack cycle) and the SRAM control waveform; expected completions go into
// a scoreboard queue that a separate monitor drains on every ack. Directed
// scenarios cover the timing examples, round robin, reset abort, early req
// drop and the extreme strobe lengths; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_pzx_sram_arbiter;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req, host_we;
    logic [20:0] host_addr;
    logic [7:0]  host_wdata;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic        play_req;
    logic [20:0] play_addr;
    logic [7:0]  play_rdata;
    logic        play_ack;
    logic [20:0] sram_addr;
    logic [7:0]  sram_dout;
    logic        sram_oe;
    logic [7:0]  sram_din;
    logic        sram_we_n;
    logic        busy;

    // Extra instances for the strobe-length extremes (player reads only).
    logic        x_req1, x_req15, x_zero;
    logic [20:0] x_addr, x_zaddr;
    logic [7:0]  x_din, x_zdata;
    logic [7:0]  x1_host_rdata, x1_play_rdata, x1_sram_dout;
    logic        x1_host_ack, x1_play_ack, x1_sram_oe, x1_sram_we_n, x1_busy;
    logic [20:0] x1_sram_addr;
    logic [7:0]  x15_host_rdata, x15_play_rdata, x15_sram_dout;
    logic        x15_host_ack, x15_play_ack, x15_sram_oe, x15_sram_we_n, x15_busy;
    logic [20:0] x15_sram_addr;

    always #5 clk = ~clk;

    pzx_sram_arbiter #(.STROBE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .play_req(play_req), .play_addr(play_addr), .play_rdata(play_rdata),
        .play_ack(play_ack), .sram_addr(sram_addr), .sram_dout(sram_dout),
        .sram_oe(sram_oe), .sram_din(sram_din), .sram_we_n(sram_we_n), .busy(busy)
    );

    pzx_sram_arbiter #(.STROBE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .host_req(x_zero), .host_we(x_zero), .host_addr(x_zaddr),
        .host_wdata(x_zdata), .host_rdata(x1_host_rdata), .host_ack(x1_host_ack),
        .play_req(x_req1), .play_addr(x_addr), .play_rdata(x1_play_rdata),
        .play_ack(x1_play_ack), .sram_addr(x1_sram_addr), .sram_dout(x1_sram_dout),
        .sram_oe(x1_sram_oe), .sram_din(x_din), .sram_we_n(x1_sram_we_n), .busy(x1_busy)
    );

    pzx_sram_arbiter #(.STROBE_CYCLES(15)) dut15 (
        .clk(clk), .rst(rst),
        .host_req(x_zero), .host_we(x_zero), .host_addr(x_zaddr),
        .host_wdata(x_zdata), .host_rdata(x15_host_rdata), .host_ack(x15_host_ack),
        .play_req(x_req15), .play_addr(x_addr), .play_rdata(x15_play_rdata),
        .play_ack(x15_play_ack), .sram_addr(x15_sram_addr), .sram_dout(x15_sram_dout),
        .sram_oe(x15_sram_oe), .sram_din(x_din), .sram_we_n(x15_sram_we_n), .busy(x15_busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- memory contents ----------------
    function automatic logic [7:0] init_val(input logic [20:0] a);
        return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'hA5;
    endfunction

    // Physical SRAM seen by the DUT: written by the DUT's strobe.
    logic [7:0] sram_mem [int];
    always @(posedge clk) begin
        if (sram_we_n === 1'b0) sram_mem[int'(sram_addr)] = sram_dout;
    end
    always @(negedge clk) begin
        sram_din = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)]
                                                    : init_val(sram_addr);
    end

    // Reference memory: updated by the model at the moment a write is granted.
    logic [7:0] ref_mem [int];
    function automatic logic [7:0] ref_rd(input logic [20:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        bit          play;
        bit          we;
        logic [20:0] addr;
        logic [7:0]  data;
        int          ack_cyc;
    } txn_t;

    txn_t        sbq [$];
    bit          armed = 1'b0;
    bit          act_v = 1'b0;
    txn_t        act;
    int          act_start = 0;
    bit          last_play = 1'b0;
    logic [20:0] m_addr = '0;
    logic [7:0]  m_dout = '0;

    always @(negedge clk) begin : model
        bit   free, in_acc, strobe, pick_play;
        txn_t t;
        if (armed) begin
            in_acc = act_v && cyc >= act_start + 1 && cyc <= act_start + S + 2;
            strobe = act_v && cyc >= act_start + 2 && cyc <= act_start + S + 1;
            check("busy", 32'(busy), 32'(in_acc));
            check("sram_oe", 32'(sram_oe), 32'(in_acc && act.we));
            check("sram_we_n", 32'(sram_we_n), 32'(!(strobe && act.we)));
            check("sram_addr", 32'(sram_addr), 32'(m_addr));
            check("sram_dout", 32'(sram_dout), 32'(m_dout));
        end
        free = !act_v;
        if (act_v && cyc == act_start + S + 2) act_v = 1'b0;
        if (rst) begin
            armed     = 1'b1;
            act_v     = 1'b0;
            last_play = 1'b0;
            m_addr    = '0;
            m_dout    = '0;
        end else if (armed && free && (host_req || play_req)) begin
            pick_play = play_req && (!host_req || !last_play);
            last_play = pick_play;
            t.play    = pick_play;
            t.we      = !pick_play && host_we;
            t.addr    = pick_play ? play_addr : host_addr;
            t.ack_cyc = cyc + S + 2;
            if (t.we) begin
                t.data = host_wdata;
                ref_mem[int'(t.addr)] = host_wdata;
                m_dout = host_wdata;
            end else begin
                t.data = ref_rd(t.addr);
            end
            m_addr    = t.addr;
            act       = t;
            act_start = cyc;
            act_v     = 1'b1;
            sbq.push_back(t);
        end
    end

    // ---------------- monitor ----------------
    bit         mon_armed = 1'b0;
    logic [7:0] e_host_rd = '0;
    logic [7:0] e_play_rd = '0;

    always @(negedge clk) begin : monitor
        txn_t t;
        if (rst) begin
            sbq.delete();
            e_host_rd = '0;
            e_play_rd = '0;
            mon_armed = 1'b1;
        end else if (mon_armed) begin
            check("ack exclusive", 32'(host_ack & play_ack), 0);
            if (host_ack || play_ack) begin
                if (sbq.size() == 0) begin
                    check("unexpected ack", 32'({host_ack, play_ack}), 0);
                end else begin
                    t = sbq.pop_front();
                    check("ack port", 32'(play_ack), 32'(t.play));
                    check("ack cycle", cyc, t.ack_cyc);
                    if (t.play) e_play_rd = t.data;
                    else if (!t.we) e_host_rd = t.data;
                    check("host_rdata", 32'(host_rdata), 32'(e_host_rd));
                    check("play_rdata", 32'(play_rdata), 32'(e_play_rd));
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].ack_cyc) begin
                check("missing ack", cyc, sbq[0].ack_cyc);
                void'(sbq.pop_front());
            end
        end
    end

    // ---------------- directed helpers ----------------
    int         ev_cyc [$];
    bit         ev_play [$];
    logic       we_n_log [32];
    logic       oe_log [32];
    logic       busy_log [32];
    logic [20:0] addr_log [32];
    logic [7:0] dout_log [32];
    int         drop_k = -1;
    int         rst_k  = -1;

    task automatic apply_reset();
        host_req = 1'b0; play_req = 1'b0; x_req1 = 1'b0; x_req15 = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Runs n cycles starting in relative cycle 0, logging acks and strobes.
    task automatic watch(input int n, input bit drop_on_ack);
        bit sh, sp;
        ev_cyc.delete();
        ev_play.delete();
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sh = host_ack;
            sp = play_ack;
            if (sh) begin ev_cyc.push_back(k); ev_play.push_back(1'b0); end
            if (sp) begin ev_cyc.push_back(k); ev_play.push_back(1'b1); end
            we_n_log[k] = sram_we_n;
            oe_log[k]   = sram_oe;
            busy_log[k] = busy;
            addr_log[k] = sram_addr;
            dout_log[k] = sram_dout;
            @(posedge clk);
            #1;
            if (drop_on_ack && sh) host_req = 1'b0;
            if (drop_on_ack && sp) play_req = 1'b0;
            if (k == drop_k) play_req = 1'b0;
            rst = (k + 1 == rst_k);
            if (k == rst_k) host_req = 1'b0;
        end
    endtask

    task automatic run_lengths();
        int a1, a15, n1, n15;
        bit s1, s15;
        a1 = -1; a15 = -1; n1 = 0; n15 = 0;
        x_req1 = 1'b1;
        x_req15 = 1'b1;
        for (int k = 0; k < 22; k++) begin
            x_din = 8'h80 + 8'(k);
            @(negedge clk);
            s1 = x1_play_ack;
            s15 = x15_play_ack;
            if (s1) begin n1++; if (a1 < 0) a1 = k; end
            if (s15) begin n15++; if (a15 < 0) a15 = k; end
            @(posedge clk);
            #1;
            if (s1) x_req1 = 1'b0;
            if (s15) x_req15 = 1'b0;
        end
        check("strobe1 ack cycle", a1, 3);
        check("strobe1 ack count", n1, 1);
        check("strobe1 rdata", 32'(x1_play_rdata), 32'h82);
        check("strobe15 ack cycle", a15, 17);
        check("strobe15 ack count", n15, 1);
        check("strobe15 rdata", 32'(x15_play_rdata), 32'h90);
        check("strobe1 idle ctrl", 32'({x1_busy, x1_sram_oe, x1_sram_we_n, x1_host_ack}), 32'b0010);
        check("strobe15 idle ctrl", 32'({x15_busy, x15_sram_oe, x15_sram_we_n, x15_host_ack}), 32'b0010);
        check("strobe1 addr", 32'(x1_sram_addr), 32'h222);
        check("strobe15 addr", 32'(x15_sram_addr), 32'h222);
        check("strobe1 host side", 32'({x1_host_rdata, x1_sram_dout}), 0);
        check("strobe15 host side", 32'({x15_host_rdata, x15_sram_dout}), 0);
    endtask

    function automatic logic [20:0] rnd_addr();
        logic [20:0] base;
        case ($urandom_range(2))
            0:       base = 21'h000000;
            1:       base = 21'h0ABC00;
            default: base = 21'h1FFF00;
        endcase
        return base + 21'($urandom_range(7));
    endfunction

    // ---------------- main sequence ----------------
    bit sh_r, sp_r;

    initial begin
        host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
        play_req = 0; play_addr = '0;
        x_req1 = 0; x_req15 = 0; x_zero = 0; x_zaddr = '0; x_zdata = '0;
        x_addr = 21'h000222; x_din = '0;
        rst = 1'b1;
        sram_mem[21'h000123] = 8'h5A;
        ref_mem[21'h000123]  = 8'h5A;

        // Reset values
        apply_reset();
        @(negedge clk);
        check("reset host_rdata", 32'(host_rdata), 0);
        check("reset play_rdata", 32'(play_rdata), 0);
        check("reset sram_addr", 32'(sram_addr), 0);
        check("reset sram_dout", 32'(sram_dout), 0);
        check("reset ctrl", 32'({busy, sram_oe, sram_we_n, host_ack, play_ack}), 32'b00100);
        @(posedge clk);
        #1;

        // Player read of 0x00123 returning 0x5A
        play_addr = 21'h000123;
        play_req  = 1'b1;
        watch(7, 1'b1);
        check("play read addr c1", 32'(addr_log[1]), 32'h123);
        check("play read ack count", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) begin
            check("play read ack cycle", ev_cyc[0], 4);
            check("play read ack port", 32'(ev_play[0]), 1);
        end
        check("play read data", 32'(play_rdata), 32'h5A);

        // Host read (so host_rdata has content), then host write to top address
        host_we = 1'b0; host_addr = 21'h000055; host_req = 1'b1;
        watch(6, 1'b1);
        check("host read data", 32'(host_rdata), 32'(init_val(21'h000055)));
        host_we = 1'b1; host_addr = 21'h1FFFFF; host_wdata = 8'hC3; host_req = 1'b1;
        watch(8, 1'b1);
        for (int k = 0; k < 7; k++) begin
            check("write we_n wave", 32'(we_n_log[k]), 32'(!(k == 2 || k == 3)));
            check("write oe wave", 32'(oe_log[k]), 32'(k >= 1 && k <= 4));
        end
        check("write dout", 32'(dout_log[1]), 32'hC3);
        check("write ack count", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) begin
            check("write ack cycle", ev_cyc[0], 4);
            check("write ack port", 32'(ev_play[0]), 0);
        end
        check("write keeps host_rdata", 32'(host_rdata), 32'(init_val(21'h000055)));
        check("write reached sram", 32'(sram_mem[int'(21'h1FFFFF)]), 32'hC3);

        // Both held continuously after reset: play, host, play, host
        apply_reset();
        host_we = 1'b0; host_addr = 21'h000010; play_addr = 21'h000020;
        host_req = 1'b1; play_req = 1'b1;
        watch(20, 1'b0);
        host_req = 1'b0; play_req = 1'b0;
        check("rr ack count", ev_cyc.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < ev_cyc.size()) begin
                check("rr ack cycle", ev_cyc[i], 4 + 5 * i);
                check("rr ack port", 32'(ev_play[i]), 32'(i % 2 == 0));
            end
        end
        repeat (6) @(posedge clk);
        #1;

        // Reset during STROBE of a host write aborts without an ack
        apply_reset();
        host_we = 1'b1; host_addr = 21'h000777; host_wdata = 8'h99; host_req = 1'b1;
        rst_k = 2;
        watch(9, 1'b1);
        rst_k = -1;
        check("abort we_n c2", 32'(we_n_log[2]), 0);
        check("abort we_n c3", 32'(we_n_log[3]), 1);
        check("abort oe c3", 32'(oe_log[3]), 0);
        check("abort busy c3", 32'(busy_log[3]), 0);
        check("abort addr c3", 32'(addr_log[3]), 0);
        check("abort dout c3", 32'(dout_log[3]), 0);
        check("abort ack count", ev_cyc.size(), 0);
        check("abort rdata", 32'({host_rdata, play_rdata}), 0);

        // Player drops req in cycle 1; access still completes
        play_addr = 21'h000300; play_req = 1'b1;
        drop_k = 0;
        watch(8, 1'b0);
        drop_k = -1;
        check("early drop ack count", ev_cyc.size(), 1);
        if (ev_cyc.size() == 1) begin
            check("early drop ack cycle", ev_cyc[0], 4);
            check("early drop ack port", 32'(ev_play[0]), 1);
        end
        check("early drop data", 32'(play_rdata), 32'(init_val(21'h000300)));

        // Strobe length extremes
        apply_reset();
        run_lengths();

        // Randomized traffic
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            sh_r = host_ack;
            sp_r = play_ack;
            @(posedge clk);
            #1;
            if (host_req && sh_r) begin
                host_req = 1'b0;
            end else if (!host_req) begin
                if ($urandom_range(3) == 0) begin
                    host_req   = 1'b1;
                    host_we    = 1'($urandom_range(1));
                    host_addr  = rnd_addr();
                    host_wdata = 8'($urandom);
                end
            end else if ($urandom_range(7) == 0) begin
                host_addr  = rnd_addr();
                host_wdata = 8'($urandom);
            end
            if (play_req && sp_r) begin
                play_req = 1'b0;
            end else if (!play_req) begin
                if ($urandom_range(3) == 0) begin
                    play_req  = 1'b1;
                    play_addr = rnd_addr();
                end
            end else if ($urandom_range(15) == 0) begin
                play_req = 1'b0;
            end else if ($urandom_range(7) == 0) begin
                play_addr = rnd_addr();
            end
        end
        host_req = 1'b0;
        play_req = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("scoreboard drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
